spi_flash_loader: RTL and testbench

//  Sequencer for the byte-wide SPI engine: autonomously reads LEN bytes from SPI flash (cmd 0x03, 24-bit addr)
//  and writes them to on-board RAM (boot/ROM load). Owns flash /CS; muxes CPU SPI strobes through while idle.

---
 rtl/spi_flash_loader_pkg.sv | 25 ++
 rtl/spi_flash_loader_spi_slot_timer.sv | 36 +++
 rtl/spi_flash_loader.sv | 174 +++++++++++++++++
 tb/tb_spi_flash_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_loader_pkg.sv
// Shared definitions for the SPI flash boot loader: sequencer states and
// the fixed bytes it places on the SPI engine.
package spi_flash_loader_pkg;

  typedef enum logic [3:0] {
    ST_SETTLE,
    ST_IDLE,
    ST_CSS,
    ST_CMD,
    ST_A2,
    ST_A1,
    ST_A0,
    ST_PRIME,
    ST_RD,
    ST_CSH
  } state_e;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam logic [7:0] READ_FILL    = 8'hFF;

  function automatic logic is_slot_state(state_e s);
    return s inside {ST_CMD, ST_A2, ST_A1, ST_A0, ST_PRIME, ST_RD};
  endfunction

endpackage

// File: rtl/spi_flash_loader_spi_slot_timer.sv
// Byte-slot timer: strobe high for XFER_CYCLES cycles, then one gap cycle,
// repeating for as long as run stays high.
module spi_slot_timer #(
  parameter int XFER_CYCLES = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic strobe_en,
  output logic last_hi,
  output logic slot_end
);

  localparam int CW = $clog2(XFER_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(XFER_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  // Down-counter: LOAD..1 is strobe-high, 0 is the gap cycle.
  always_comb begin
    cnt_d = LOAD;
    if (run) begin
      cnt_d = (cnt_q == '0) ? LOAD : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= LOAD;
    else        cnt_q <= cnt_d;
  end

  assign strobe_en = run && (cnt_q != '0);
  assign last_hi   = run && (cnt_q == CW'(1));
  assign slot_end  = run && (cnt_q == '0);

endmodule

// File: rtl/spi_flash_loader.sv
// Boot loader sequencer: reads a block from SPI flash through the byte
// engine and writes it into RAM; passes CPU SPI strobes through while idle.
module spi_flash_loader
  import spi_flash_loader_pkg::*;
#(
  parameter int XFER_CYCLES = 18,
  parameter int CS_SETUP    = 2,
  parameter int MEM_AW      = 19,
  parameter int LEN_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [23:0]       flash_addr,
  input  logic [MEM_AW-1:0] mem_base,
  input  logic [LEN_W-1:0]  length,
  output logic              ready,
  output logic              busy,
  output logic              done,
  input  logic              cpu_enviar,
  input  logic              cpu_recibir,
  input  logic [7:0]        cpu_din,
  output logic              spi_enviar,
  output logic              spi_recibir,
  output logic [7:0]        spi_din,
  input  logic [7:0]        spi_dout,
  output logic              flash_cs_n,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we
);

  localparam int WW = $clog2(XFER_CYCLES + CS_SETUP + 1);

  state_e            state_q, state_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [23:0]       faddr_q, faddr_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d, mem_addr_q, mem_addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              mem_we_q, mem_we_d, done_q, done_d;
  logic              idle, strobe_en, last_hi, slot_end;

  assign idle = (state_q == ST_IDLE);

  spi_slot_timer #(.XFER_CYCLES(XFER_CYCLES)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (is_slot_state(state_q)),
    .strobe_en (strobe_en),
    .last_hi   (last_hi),
    .slot_end  (slot_end)
  );

  assign ready      = idle && !cpu_enviar && !cpu_recibir;
  assign busy       = !(state_q inside {ST_SETTLE, ST_IDLE});
  assign flash_cs_n = !busy;
  assign done       = done_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_we     = mem_we_q;

  always_comb begin
    spi_enviar  = 1'b0;
    spi_recibir = 1'b0;
    spi_din     = '0;
    case (state_q)
      ST_IDLE: begin
        spi_enviar  = cpu_enviar;
        spi_recibir = cpu_recibir;
        spi_din     = cpu_din;
      end
      ST_CMD:   begin spi_enviar = strobe_en; spi_din = SPI_CMD_READ;    end
      ST_A2:    begin spi_enviar = strobe_en; spi_din = faddr_q[23:16]; end
      ST_A1:    begin spi_enviar = strobe_en; spi_din = faddr_q[15:8];  end
      ST_A0:    begin spi_enviar = strobe_en; spi_din = faddr_q[7:0];   end
      ST_PRIME, ST_RD: begin
        spi_recibir = strobe_en;
        spi_din     = READ_FILL;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    faddr_d    = faddr_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        if (wait_q == '0) state_d = ST_IDLE;
        else              wait_d  = wait_q - 1'b1;
      end
      ST_IDLE: begin
        if (start && ready) begin
          faddr_d = flash_addr;
          ptr_d   = mem_base;
          len_d   = length;
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_CSS;
            wait_d  = WW'(CS_SETUP - 1);
          end
        end
      end
      ST_CSS: begin
        if (wait_q == '0) state_d = ST_CMD;
        else              wait_d  = wait_q - 1'b1;
      end
      ST_CMD:   if (slot_end) state_d = ST_A2;
      ST_A2:    if (slot_end) state_d = ST_A1;
      ST_A1:    if (slot_end) state_d = ST_A0;
      ST_A0:    if (slot_end) state_d = ST_PRIME;
      ST_PRIME: if (slot_end) state_d = ST_RD;
      ST_RD: begin
        // Byte is stable on the engine output by the last strobe-high cycle.
        if (last_hi) begin
          mem_data_d = spi_dout;
          mem_addr_d = ptr_q;
          ptr_d      = ptr_q + 1'b1;
          mem_we_d   = 1'b1;
        end
        if (slot_end) begin
          len_d = len_q - 1'b1;
          if (len_q == LEN_W'(1)) begin
            state_d = ST_CSH;
            wait_d  = WW'(CS_SETUP - 1);
          end
        end
      end
      ST_CSH: begin
        if (wait_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_SETTLE;
      wait_q     <= WW'(XFER_CYCLES - 1);
      faddr_q    <= '0;
      ptr_q      <= '0;
      len_q      <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      faddr_q    <= faddr_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_loader.sv
// Self-checking bench: SPI flash + byte-engine model and RAM-write scoreboard
// for the flash boot loader.
module tb_spi_flash_loader;

  localparam int XFER     = 18;
  localparam int CS_SETUP = 2;

  typedef struct {
    logic [7:0] b;
    logic       rd;
  } mosi_t;

  typedef struct {
    logic [18:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] flash_addr = '0;
  logic [18:0] mem_base = '0;
  logic [15:0] length = '0;
  logic        ready, busy, done;
  logic        cpu_enviar = 1'b0, cpu_recibir = 1'b0;
  logic [7:0]  cpu_din = '0;
  logic        spi_enviar, spi_recibir;
  logic [7:0]  spi_din;
  logic [7:0]  spi_dout = '0;
  logic        flash_cs_n;
  logic [18:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;

  spi_flash_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flash_addr(flash_addr),
    .mem_base(mem_base), .length(length), .ready(ready), .busy(busy),
    .done(done), .cpu_enviar(cpu_enviar), .cpu_recibir(cpu_recibir),
    .cpu_din(cpu_din), .spi_enviar(spi_enviar), .spi_recibir(spi_recibir),
    .spi_din(spi_din), .spi_dout(spi_dout), .flash_cs_n(flash_cs_n),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int we_count = 0;
  int done_count = 0;

  logic [7:0] flash_mem [logic [23:0]];
  mosi_t exp_mosi_q[$];
  wr_t   exp_wr_q[$];

  // engine / flash slave model state
  int          fbyte = 0;
  int          hi_len = 0;
  int          lo_len = 0;
  logic        prev_strb = 1'b0;
  logic [23:0] slave_addr = '0;
  logic [7:0]  last_miso = 8'hFF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string nm, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (flash_mem.exists(a)) return flash_mem[a];
    return a[7:0] ^ {a[11:8], a[19:16]} ^ 8'h5C;
  endfunction

  task automatic push_m(input logic [7:0] b, input logic rd);
    mosi_t m;
    m.b = b; m.rd = rd;
    exp_mosi_q.push_back(m);
  endtask

  task automatic push_w(input logic [18:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a; w.d = d;
    exp_wr_q.push_back(w);
  endtask

  task automatic push_mosi(input logic [23:0] fa, input int len);
    push_m(8'h03, 1'b0);
    push_m(fa[23:16], 1'b0);
    push_m(fa[15:8], 1'b0);
    push_m(fa[7:0], 1'b0);
    for (int i = 0; i <= len; i++) push_m(8'hFF, 1'b1);
  endtask

  task automatic push_model_writes(input logic [23:0] fa, input logic [18:0] base, input int len);
    for (int i = 0; i < len; i++) push_w(19'(base + 19'(i)), flash_byte(24'(fa + 24'(i))));
  endtask

  // Flash slave + engine model and scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    logic strb;
    strb = spi_enviar | spi_recibir;
    if (rst_n && mem_we) begin
      we_count++;
      if (exp_wr_q.size() == 0) begin
        check("unexpected_mem_we", 32'(mem_addr), 32'hFFFFFFFF);
      end else begin
        wr_t w;
        w = exp_wr_q.pop_front();
        check("mem_addr", 32'(mem_addr), 32'(w.a));
        check("mem_data", 32'(mem_data), 32'(w.d));
      end
    end
    if (done) done_count++;
    if (flash_cs_n) begin
      fbyte = 0;
      hi_len = 0;
      lo_len = 0;
    end else if (strb && !prev_strb) begin
      if (fbyte > 0) check("gap_cycles", 32'(lo_len), 1);
      if (exp_mosi_q.size() == 0) begin
        check("extra_slot", 32'(spi_din), 32'hFFFFFFFF);
      end else begin
        mosi_t m;
        m = exp_mosi_q.pop_front();
        check("mosi_byte", 32'(spi_din), 32'(m.b));
        check("strobe_kind", 32'({spi_enviar, spi_recibir}), m.rd ? 32'b01 : 32'b10);
      end
      if (fbyte >= 1 && fbyte <= 3) slave_addr = {slave_addr[15:0], spi_din};
      spi_dout  = last_miso;
      last_miso = (fbyte >= 4) ? flash_byte(24'(slave_addr + 24'(fbyte - 4))) : 8'hFF;
      fbyte++;
      hi_len = 1;
    end else if (strb) begin
      hi_len++;
    end else if (prev_strb) begin
      check("strobe_width", 32'(hi_len), XFER);
      lo_len = 1;
    end else begin
      lo_len++;
    end
    prev_strb = strb;
  end

  task automatic settle_check();
    for (int i = 0; i < XFER; i++) begin
      if (i > 0) begin @(posedge clk); @(negedge clk); end
      check("settle_ready", 32'(ready), 0);
      check("settle_cs_n", 32'(flash_cs_n), 1);
      check("settle_strobes", 32'({spi_enviar, spi_recibir}), 0);
      if (i == 0) begin
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_data", 32'(mem_data), 0);
        check("rst_spi_din", 32'(spi_din), 0);
      end
    end
    @(posedge clk); @(negedge clk);
    check("settle_end_ready", 32'(ready), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    settle_check();
  endtask

  task automatic run_load(input logic [23:0] fa, input logic [18:0] base,
                          input logic [15:0] len, input bit jitter);
    int n, d, dc0, c0, expd;
    bit got;
    logic pb;
    n = 0;
    while (!ready && n < 200) begin @(posedge clk); @(negedge clk); n++; end
    check("ready_before_start", 32'(ready), 1);
    flash_addr = fa; mem_base = base; length = len; start = 1'b1;
    dc0 = done_count;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    if (len == 0) begin
      check("len0_done", 32'(done), 1);
      check("len0_busy", 32'(busy), 0);
      repeat (4) begin
        @(posedge clk); @(negedge clk);
        check("len0_cs_n", 32'(flash_cs_n), 1);
        check("len0_done_once", 32'(done), 0);
      end
    end else begin
      check("busy_after_start", 32'(busy), 1);
      expd = 2 * CS_SETUP + (5 + int'(len)) * (XFER + 1);
      got = 0; d = 0; pb = 1'b0;
      for (n = 0; n < expd + 50 && !got; n++) begin
        if (jitter) begin
          cpu_enviar  = 1'($urandom_range(0, 1));
          cpu_recibir = 1'($urandom_range(0, 1));
          cpu_din     = 8'($urandom);
        end
        pb = busy;
        @(posedge clk); @(negedge clk);
        if (done) begin got = 1; d = cyc - c0; end
      end
      cpu_enviar = 1'b0; cpu_recibir = 1'b0;
      check("done_seen", 32'(got), 1);
      check("busy_fall_with_done", 32'({pb, busy}), 32'b10);
      check_range("load_duration", d, expd - 1, expd + 1);
      @(posedge clk); @(negedge clk);
      check("done_pulse_width", 32'(done), 0);
    end
    check("done_count", 32'(done_count - dc0), 1);
    check("writes_pending", 32'(exp_wr_q.size()), 0);
    check("mosi_pending", 32'(exp_mosi_q.size()), 0);
  endtask

  task automatic idle_cpu_traffic(input int ncyc);
    int b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      cpu_enviar  = 1'($urandom_range(0, 1));
      cpu_recibir = 1'($urandom_range(0, 1));
      cpu_din     = 8'($urandom);
      start       = cpu_enviar | cpu_recibir;
      #1;
      check("pt_enviar", 32'(spi_enviar), 32'(cpu_enviar));
      check("pt_recibir", 32'(spi_recibir), 32'(cpu_recibir));
      check("pt_din", 32'(spi_din), 32'(cpu_din));
      check("pt_ready", 32'(ready), 32'(!(cpu_enviar | cpu_recibir)));
      b0 = done_count;
      @(posedge clk); #1;
      start = 1'b0;
      check("ignored_start_busy", 32'(busy), 0);
    end
    @(negedge clk);
    cpu_enviar = 1'b0; cpu_recibir = 1'b0; start = 1'b0;
    @(negedge clk);
    check("ignored_start_no_done", 32'(done), 0);
  endtask

  initial begin
    int w0, n;
    logic [23:0] fa;
    logic [18:0] base;
    logic [15:0] len;

    do_reset();

    // CPU pass-through and masked start
    @(negedge clk);
    cpu_enviar = 1'b1; cpu_din = 8'h5A; start = 1'b1; length = 16'd3;
    #1;
    check("cpu_pt_enviar", 32'(spi_enviar), 1);
    check("cpu_pt_din", 32'(spi_din), 32'h5A);
    check("cpu_pt_ready", 32'(ready), 0);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("start_ignored_busy", 32'(busy), 0);
    check("start_ignored_cs", 32'(flash_cs_n), 1);
    cpu_enviar = 1'b0; cpu_din = 8'h00;
    repeat (3) begin @(posedge clk); @(negedge clk); check("start_ignored_done", 32'(done), 0); end

    // Directed load with literal expectations
    flash_mem[24'h012345] = 8'h11;
    flash_mem[24'h012346] = 8'h22;
    flash_mem[24'h012347] = 8'h33;
    flash_mem[24'h012348] = 8'h44;
    push_m(8'h03, 1'b0); push_m(8'h01, 1'b0); push_m(8'h23, 1'b0); push_m(8'h45, 1'b0);
    for (int i = 0; i < 5; i++) push_m(8'hFF, 1'b1);
    push_w(19'h00100, 8'h11); push_w(19'h00101, 8'h22);
    push_w(19'h00102, 8'h33); push_w(19'h00103, 8'h44);
    run_load(24'h012345, 19'h00100, 16'd4, 1'b0);

    // Zero length
    w0 = we_count;
    run_load(24'h00ABCD, 19'h00200, 16'd0, 1'b0);
    check("len0_no_we", 32'(we_count - w0), 0);

    // Address wrap
    push_mosi(24'h3C0010, 3);
    push_w(19'h7FFFE, flash_byte(24'h3C0010));
    push_w(19'h7FFFF, flash_byte(24'h3C0011));
    push_w(19'h00000, flash_byte(24'h3C0012));
    run_load(24'h3C0010, 19'h7FFFE, 16'd3, 1'b0);

    // Randomised loads with CPU traffic in between and during
    for (int k = 0; k < 6; k++) begin
      idle_cpu_traffic(4);
      fa   = 24'($urandom);
      base = (k % 2 == 0) ? 19'($urandom) : 19'(19'h7FFFF - 19'($urandom_range(0, 3)));
      len  = 16'($urandom_range(1, 6));
      push_mosi(fa, int'(len));
      push_model_writes(fa, base, int'(len));
      run_load(fa, base, len, 1'b1);
    end

    // Reset during the second read slot
    fa = 24'h0F1E2D; base = 19'h01230; len = 16'd5;
    push_mosi(fa, 5);
    push_model_writes(fa, base, 5);
    w0 = we_count;
    @(negedge clk);
    flash_addr = fa; mem_base = base; length = len; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    n = 0;
    while (we_count == w0 && n < 400) begin @(posedge clk); @(negedge clk); n++; end
    check("abort_first_we_seen", 32'(we_count - w0), 1);
    repeat (5) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort_cs_n", 32'(flash_cs_n), 1);
    check("abort_strobes", 32'({spi_enviar, spi_recibir}), 0);
    check("abort_busy", 32'(busy), 0);
    repeat (2) begin @(posedge clk); @(negedge clk); check("abort_no_we", 32'(mem_we), 0); end
    check("abort_we_total", 32'(we_count - w0), 1);
    exp_wr_q.delete();
    exp_mosi_q.delete();
    rst_n = 1'b1;
    settle_check();

    fa = 24'h7000F0; base = 19'h04000; len = 16'd4;
    push_mosi(fa, 4);
    push_model_writes(fa, base, 4);
    run_load(fa, base, len, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
